// File: rtl/vector_reg_file_masked_pkg.sv
// ============================================================================
// vrf_pkg
// ----------------------------------------------------------------------------
// Shared types and default parameter values for the masked vector register
// file. The element and vector typedefs describe the default geometry. Modules
// with a different geometry build their own local vector type from their
// parameters.
//
// Contents:
//   DEF_*        default parameter values used by the register file modules
//   elem_t       one lane element (DEF_ELEM_W bits)
//   vec_t        one vector (DEF_LANES packed elem_t, lane 0 in the LSBs)
//   clr_state_t  bulk-clear sequencer states
// ============================================================================
package vrf_pkg;

    localparam int DEF_ELEM_W    = 16;
    localparam int DEF_LANES     = 4;
    localparam int DEF_NUM_REGS  = 8;
    localparam int DEF_WR_BYPASS = 1;
    localparam int DEF_ZERO_REG  = 0;

    typedef logic [DEF_ELEM_W-1:0] elem_t;
    typedef elem_t [DEF_LANES-1:0] vec_t;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } clr_state_t;

endpackage

// File: rtl/vector_reg_file_masked_if.sv
// ============================================================================
// vector_reg_file_masked_if
// ----------------------------------------------------------------------------
// Bundles the read ports, the masked write port and the bulk-clear handshake
// of the vector register file. The register file connects through the slave
// modport. The decoder (or a testbench) connects through the master modport.
//
// Signals:
//   rd_sel1/rd_sel2    read port register selects
//   rd_data1/rd_data2  read port vectors (lane k at bits k*ELEM_W +: ELEM_W)
//   wr_en              write request
//   wr_sel             destination register
//   wr_mask            per-lane write enable
//   wr_data            write vector
//   wr_ready           write port accepts (low while the clear engine runs)
//   clr_req            bulk clear request (level)
//   clr_busy           clear in progress
//   clr_done           one-cycle pulse when the clear has finished
// ============================================================================
interface vector_reg_file_masked_if
    import vrf_pkg::*;
#(
    parameter int ELEM_W   = DEF_ELEM_W,
    parameter int LANES    = DEF_LANES,
    parameter int NUM_REGS = DEF_NUM_REGS
);

    localparam int SEL_W = $clog2(NUM_REGS);

    logic [SEL_W-1:0]        rd_sel1;
    logic [SEL_W-1:0]        rd_sel2;
    logic [LANES*ELEM_W-1:0] rd_data1;
    logic [LANES*ELEM_W-1:0] rd_data2;
    logic                    wr_en;
    logic [SEL_W-1:0]        wr_sel;
    logic [LANES-1:0]        wr_mask;
    logic [LANES*ELEM_W-1:0] wr_data;
    logic                    wr_ready;
    logic                    clr_req;
    logic                    clr_busy;
    logic                    clr_done;

    modport master (
        output rd_sel1, rd_sel2, wr_en, wr_sel, wr_mask, wr_data, clr_req,
        input  rd_data1, rd_data2, wr_ready, clr_busy, clr_done
    );

    modport slave (
        input  rd_sel1, rd_sel2, wr_en, wr_sel, wr_mask, wr_data, clr_req,
        output rd_data1, rd_data2, wr_ready, clr_busy, clr_done
    );

endinterface

// File: rtl/vector_reg_file_masked_clear_fsm.sv
// ============================================================================
// vrf_clear_fsm
// ----------------------------------------------------------------------------
// Sequencer for the bulk clear of the vector register file. A request seen in
// IDLE starts a sweep that zeroes one register per cycle, from register 0 up to
// NUM_REGS-1. A single DONE cycle then pulses clr_done. The external write port
// is held off for the whole sweep, DONE included.
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   clr_req    clear request, sampled only in IDLE
//   clr_we     zero the register addressed by clr_sel this cycle
//   clr_sel    register being cleared
//   clr_busy   high in CLEAR and DONE
//   clr_done   high for the single DONE cycle
//   wr_ready   high only in IDLE
// ============================================================================
module vrf_clear_fsm
    import vrf_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr_req,
    output logic                        clr_we,
    output logic [$clog2(NUM_REGS)-1:0] clr_sel,
    output logic                        clr_busy,
    output logic                        clr_done,
    output logic                        wr_ready
);

    localparam int SEL_W = $clog2(NUM_REGS);
    localparam logic [SEL_W-1:0] LAST_REG = SEL_W'(NUM_REGS - 1);

    clr_state_t       state;
    clr_state_t       state_next;
    logic [SEL_W-1:0] cnt;
    logic [SEL_W-1:0] cnt_next;

    // State and counter registers. Reset aborts any sweep in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The counter stops at the last register and returns to 0. It never wraps
    // on its own, so the sweep length is exactly NUM_REGS cycles.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clr_we     = 1'b0;
        clr_sel    = cnt;
        clr_busy   = 1'b0;
        clr_done   = 1'b0;
        wr_ready   = 1'b1;

        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                clr_we   = 1'b1;
                clr_busy = 1'b1;
                wr_ready = 1'b0;
                if (cnt == LAST_REG) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + SEL_W'(1);
                end
            end
            DONE: begin
                clr_busy   = 1'b1;
                clr_done   = 1'b1;
                wr_ready   = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/vector_reg_file_masked.sv
// ============================================================================
// vector_reg_file_masked
// ----------------------------------------------------------------------------
// Vector register file that supplies operands to the SIMD execute stage. It
// holds NUM_REGS registers of LANES x ELEM_W bits. It has two combinational
// read ports and one write port with a per-lane mask. Options:
//   WR_BYPASS  read ports see a write that commits in the same cycle
//   ZERO_REG   register 0 reads as zero and ignores writes
// A bulk-clear engine (vrf_clear_fsm) zeroes the registers one per cycle and
// blocks the write port while it runs.
//
// Ports:
//   clk   clock, all state updates on the rising edge
//   rst   asynchronous active-high reset, zeroes every register
//   bus   vector_reg_file_masked_if.slave (read, write and clear signals)
// ============================================================================
module vector_reg_file_masked
    import vrf_pkg::*;
#(
    parameter int ELEM_W    = DEF_ELEM_W,
    parameter int LANES     = DEF_LANES,
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int WR_BYPASS = DEF_WR_BYPASS,
    parameter int ZERO_REG  = DEF_ZERO_REG
) (
    input  logic                           clk,
    input  logic                           rst,
    vector_reg_file_masked_if.slave        bus
);

    localparam int SEL_W = $clog2(NUM_REGS);

    typedef logic [LANES-1:0][ELEM_W-1:0] lane_vec_t;

    lane_vec_t        mem [NUM_REGS];
    lane_vec_t        wr_vec;
    logic             clr_we;
    logic [SEL_W-1:0] clr_sel;
    logic             wr_ready;
    logic             wr_commit;

    assign wr_vec = bus.wr_data;

    vrf_clear_fsm #(
        .NUM_REGS (NUM_REGS)
    ) u_clear_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (bus.clr_req),
        .clr_we   (clr_we),
        .clr_sel  (clr_sel),
        .clr_busy (bus.clr_busy),
        .clr_done (bus.clr_done),
        .wr_ready (wr_ready)
    );

    assign bus.wr_ready = wr_ready;

    // With ZERO_REG set, a write to register 0 is never accepted. Because of
    // this, bypass never exposes write data for register 0.
    assign wr_commit = bus.wr_en && wr_ready &&
                       ((bus.wr_sel != '0) || (ZERO_REG == 0));

    // Storage. A clear write and an external write cannot coincide, because
    // wr_ready is low whenever clr_we is high. The clear still takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_we) begin
            mem[clr_sel] <= '0;
        end else if (wr_commit) begin
            for (int k = 0; k < LANES; k++) begin
                if (bus.wr_mask[k]) begin
                    mem[bus.wr_sel][k] <= wr_vec[k];
                end
            end
        end
    end

    // One read port. Clear writes are never bypassed, so a register being
    // cleared keeps reading its old contents until the edge.
    function automatic lane_vec_t read_port(
        input logic [SEL_W-1:0] sel,
        input lane_vec_t        stored,
        input logic             commit,
        input logic [SEL_W-1:0] wsel,
        input logic [LANES-1:0] wmask,
        input lane_vec_t        wdata
    );
        lane_vec_t result;
        result = stored;
        if ((WR_BYPASS != 0) && commit && (sel == wsel)) begin
            for (int k = 0; k < LANES; k++) begin
                if (wmask[k]) begin
                    result[k] = wdata[k];
                end
            end
        end
        if ((ZERO_REG != 0) && (sel == '0)) begin
            result = '0;
        end
        return result;
    endfunction

    assign bus.rd_data1 = read_port(bus.rd_sel1, mem[bus.rd_sel1], wr_commit,
                                    bus.wr_sel, bus.wr_mask, wr_vec);
    assign bus.rd_data2 = read_port(bus.rd_sel2, mem[bus.rd_sel2], wr_commit,
                                    bus.wr_sel, bus.wr_mask, wr_vec);

endmodule

// File: tb/tb_vector_reg_file_masked.sv
// ============================================================================
// tb_vector_reg_file_masked
// ----------------------------------------------------------------------------
// Three register files are driven from one shared stimulus:
//   dut_a  WR_BYPASS=1, ZERO_REG=0
//   dut_n  WR_BYPASS=0, ZERO_REG=0
//   dut_z  WR_BYPASS=1, ZERO_REG=1
// A table of directed vectors covers reads, masked writes, bypass and the
// hardwired zero register. Hand-written sequences cover bulk clear, clr_req
// held through DONE, a write together with a clear request, and reset in the
// middle of a clear.
// ============================================================================
module tb_vector_reg_file_masked;
    import vrf_pkg::*;

    localparam int EW = 16;
    localparam int LN = 4;
    localparam int NR = 8;
    localparam int SW = 3;
    localparam int VW = EW * LN;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic [SW-1:0] rd_sel1, rd_sel2, wr_sel;
    logic          wr_en, clr_req;
    logic [LN-1:0] wr_mask;
    logic [VW-1:0] wr_data;

    vector_reg_file_masked_if #(.ELEM_W(EW), .LANES(LN), .NUM_REGS(NR)) bus_a ();
    vector_reg_file_masked_if #(.ELEM_W(EW), .LANES(LN), .NUM_REGS(NR)) bus_n ();
    vector_reg_file_masked_if #(.ELEM_W(EW), .LANES(LN), .NUM_REGS(NR)) bus_z ();

    assign bus_a.rd_sel1 = rd_sel1;
    assign bus_a.rd_sel2 = rd_sel2;
    assign bus_a.wr_en   = wr_en;
    assign bus_a.wr_sel  = wr_sel;
    assign bus_a.wr_mask = wr_mask;
    assign bus_a.wr_data = wr_data;
    assign bus_a.clr_req = clr_req;

    assign bus_n.rd_sel1 = rd_sel1;
    assign bus_n.rd_sel2 = rd_sel2;
    assign bus_n.wr_en   = wr_en;
    assign bus_n.wr_sel  = wr_sel;
    assign bus_n.wr_mask = wr_mask;
    assign bus_n.wr_data = wr_data;
    assign bus_n.clr_req = clr_req;

    assign bus_z.rd_sel1 = rd_sel1;
    assign bus_z.rd_sel2 = rd_sel2;
    assign bus_z.wr_en   = wr_en;
    assign bus_z.wr_sel  = wr_sel;
    assign bus_z.wr_mask = wr_mask;
    assign bus_z.wr_data = wr_data;
    assign bus_z.clr_req = clr_req;

    vector_reg_file_masked #(.ELEM_W(EW), .LANES(LN), .NUM_REGS(NR),
                             .WR_BYPASS(1), .ZERO_REG(0))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    vector_reg_file_masked #(.ELEM_W(EW), .LANES(LN), .NUM_REGS(NR),
                             .WR_BYPASS(0), .ZERO_REG(0))
        dut_n (.clk(clk), .rst(rst), .bus(bus_n));
    vector_reg_file_masked #(.ELEM_W(EW), .LANES(LN), .NUM_REGS(NR),
                             .WR_BYPASS(1), .ZERO_REG(1))
        dut_z (.clk(clk), .rst(rst), .bus(bus_z));

    int n_cmp = 0;
    int n_bad = 0;

    // Fields: read selects, write request, then expected pre-edge reads.
    // e1/e2 belong to dut_a, en1 to dut_n port 1, ez1 to dut_z port 1.
    typedef struct {
        logic [SW-1:0] s1;
        logic [SW-1:0] s2;
        logic          we;
        logic [SW-1:0] ws;
        logic [LN-1:0] m;
        logic [VW-1:0] d;
        logic [VW-1:0] e1;
        logic [VW-1:0] e2;
        logic [VW-1:0] en1;
        logic [VW-1:0] ez1;
    } vec_row_t;

    vec_row_t tbl [14];

    function automatic vec_row_t make_row(
        input logic [SW-1:0] s1, input logic [SW-1:0] s2, input logic we,
        input logic [SW-1:0] ws, input logic [LN-1:0] m, input logic [VW-1:0] d,
        input logic [VW-1:0] e1, input logic [VW-1:0] e2,
        input logic [VW-1:0] en1, input logic [VW-1:0] ez1);
        vec_row_t r;
        r.s1 = s1; r.s2 = s2; r.we = we; r.ws = ws; r.m = m; r.d = d;
        r.e1 = e1; r.e2 = e2; r.en1 = en1; r.ez1 = ez1;
        return r;
    endfunction

    function automatic vec_t rep(input elem_t e);
        return {e, e, e, e};
    endfunction

    task automatic applyStimulus(input vec_row_t r);
        rd_sel1 = r.s1;
        rd_sel2 = r.s2;
        wr_en   = r.we;
        wr_sel  = r.ws;
        wr_mask = r.m;
        wr_data = r.d;
    endtask

    task automatic checkOutput(input string name, input logic [VW-1:0] act,
                               input logic [VW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkStatus(input string name, input logic busy,
                               input logic done, input logic ready);
        checkOutput({name, " clr_busy"}, VW'(bus_a.clr_busy), VW'(busy));
        checkOutput({name, " clr_done"}, VW'(bus_a.clr_done), VW'(done));
        checkOutput({name, " wr_ready"}, VW'(bus_a.wr_ready), VW'(ready));
    endtask

    initial begin
        logic [VW-1:0] v0123, vmask, vby, vff, vff3;
        v0123 = 64'h0004_0003_0002_0001;
        vmask = 64'h0004_AAAA_0002_AAAA;
        vby   = 64'h0000_0000_1234_1234;
        vff   = 64'hFFFF_FFFF_FFFF_FFFF;
        vff3  = 64'h0000_FFFF_FFFF_FFFF;

        //                 s1    s2    we    ws    mask     data         e1     e2     en1    ez1
        tbl[0]  = make_row(3'd0, 3'd1, 1'b0, 3'd0, 4'b0000, '0,          '0,    '0,    '0,    '0);
        tbl[1]  = make_row(3'd3, 3'd5, 1'b1, 3'd3, 4'b1111, v0123,       v0123, '0,    '0,    v0123);
        tbl[2]  = make_row(3'd3, 3'd5, 1'b0, 3'd0, 4'b0000, '0,          v0123, '0,    v0123, v0123);
        tbl[3]  = make_row(3'd3, 3'd3, 1'b1, 3'd3, 4'b0101, rep(16'hAAAA), vmask, vmask, v0123, vmask);
        tbl[4]  = make_row(3'd3, 3'd2, 1'b0, 3'd0, 4'b0000, '0,          vmask, '0,    vmask, vmask);
        tbl[5]  = make_row(3'd2, 3'd3, 1'b1, 3'd2, 4'b0011, rep(16'h1234), vby, vmask, '0,    vby);
        tbl[6]  = make_row(3'd2, 3'd2, 1'b0, 3'd0, 4'b0000, '0,          vby,   vby,   vby,   vby);
        tbl[7]  = make_row(3'd5, 3'd5, 1'b1, 3'd5, 4'b0000, vff,         '0,    '0,    '0,    '0);
        tbl[8]  = make_row(3'd5, 3'd1, 1'b0, 3'd0, 4'b0000, '0,          '0,    '0,    '0,    '0);
        tbl[9]  = make_row(3'd0, 3'd1, 1'b1, 3'd0, 4'b1111, vff,         vff,   '0,    '0,    '0);
        tbl[10] = make_row(3'd0, 3'd0, 1'b0, 3'd0, 4'b0000, '0,          vff,   vff,   vff,   '0);
        tbl[11] = make_row(3'd1, 3'd0, 1'b1, 3'd1, 4'b1111, vff,         vff,   vff,   '0,    vff);
        tbl[12] = make_row(3'd1, 3'd3, 1'b1, 3'd1, 4'b1000, '0,          vff3,  vmask, vff,   vff3);
        tbl[13] = make_row(3'd1, 3'd2, 1'b0, 3'd0, 4'b0000, '0,          vff3,  vby,   vff3,  vff3);

        rst = 1'b1;
        rd_sel1 = '0; rd_sel2 = '0; wr_en = 1'b0; wr_sel = '0;
        wr_mask = '0; wr_data = '0; clr_req = 1'b0;

        // Reset state
        @(negedge clk);
        #2;
        checkStatus("reset", 1'b0, 1'b0, 1'b1);
        checkOutput("reset rd_data1", bus_a.rd_data1, '0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors, checked before the edge that commits them
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            applyStimulus(tbl[i]);
            #2;
            checkOutput($sformatf("row%0d a.rd_data1", i), bus_a.rd_data1, tbl[i].e1);
            checkOutput($sformatf("row%0d a.rd_data2", i), bus_a.rd_data2, tbl[i].e2);
            checkOutput($sformatf("row%0d n.rd_data1", i), bus_n.rd_data1, tbl[i].en1);
            checkOutput($sformatf("row%0d z.rd_data1", i), bus_z.rd_data1, tbl[i].ez1);
        end

        // Fill every register, then run a full clear
        for (int i = 0; i < NR; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_sel = SW'(i); wr_mask = 4'b1111;
            wr_data = rep(16'h1100 + 16'(i));
        end
        @(negedge clk);
        wr_en = 1'b0; clr_req = 1'b1;
        #2;
        checkStatus("clr idle", 1'b0, 1'b0, 1'b1);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            clr_req = 1'b0;
            wr_en = (c == 2); wr_sel = 3'd7; wr_mask = 4'b1111;
            wr_data = rep(16'h5555);
            if (c <= 8) begin
                rd_sel1 = SW'(c - 1);
                rd_sel2 = (c >= 2) ? SW'(c - 2) : 3'd7;
            end
            #2;
            checkStatus($sformatf("clr c%0d", c), 1'b1, (c == 9), 1'b0);
            if (c <= 8) begin
                checkOutput($sformatf("clr c%0d reg being cleared", c), bus_a.rd_data1,
                            rep(16'h1100 + 16'(c - 1)));
                checkOutput($sformatf("clr c%0d other reg", c), bus_a.rd_data2,
                            (c >= 2) ? '0 : rep(16'h1107));
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
        #2;
        checkStatus("clr after", 1'b0, 1'b0, 1'b1);
        for (int s = 0; s < NR; s++) begin
            rd_sel1 = SW'(s);
            #1;
            checkOutput($sformatf("clr zero reg%0d", s), bus_a.rd_data1, '0);
        end

        // Write together with clr_req in IDLE, and clr_req held through DONE
        @(negedge clk);
        clr_req = 1'b1; wr_en = 1'b1; wr_sel = 3'd6; wr_mask = 4'b1111;
        wr_data = rep(16'h7777); rd_sel1 = 3'd6;
        #2;
        checkStatus("hold start", 1'b0, 1'b0, 1'b1);
        checkOutput("hold start bypass", bus_a.rd_data1, rep(16'h7777));
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            wr_en = 1'b0;
            clr_req = (c < 10);
            #2;
            checkStatus($sformatf("hold c%0d", c), (c <= 9), (c == 9), (c > 9));
            checkOutput($sformatf("hold c%0d reg6", c), bus_a.rd_data1,
                        (c <= 7) ? rep(16'h7777) : '0);
        end

        // Reset while the clear engine is at register 4
        @(negedge clk);
        wr_en = 1'b1; wr_sel = 3'd5; wr_mask = 4'b1111; wr_data = rep(16'h5A5A);
        @(negedge clk);
        wr_sel = 3'd7; wr_data = rep(16'h7A7A);
        @(negedge clk);
        wr_en = 1'b0; clr_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            clr_req = 1'b0;
        end
        rd_sel1 = 3'd5; rd_sel2 = 3'd7;
        #2;
        checkOutput("mid-clear reg5 old", bus_a.rd_data1, rep(16'h5A5A));
        checkStatus("mid-clear", 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checkStatus("abort", 1'b0, 1'b0, 1'b1);
        checkOutput("abort reg5", bus_a.rd_data1, '0);
        checkOutput("abort reg7", bus_a.rd_data2, '0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            #2;
            checkStatus($sformatf("post-abort c%0d", c), 1'b0, 1'b0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vector_reg_file_masked.md
Name: vector_reg_file_masked

Overview:
- Parametrised next-generation vector register file for the decoder stage.
- Provides NUM_REGS registers of LANES lanes × ELEM_W bits each.
- Has two combinational read ports and one write port with a per-lane write mask.
- Adds optional read-during-write bypass, an optional hardwired-zero register 0, and a sequenced bulk-clear engine with a ready/done handshake. It feeds the SIMD execute stage operands.

Parameters:
- ELEM_W, 16, bits per lane element
- LANES, 4, lanes per vector
- NUM_REGS, 8, number of vector registers (≥2, power of 2)
- SEL_W, $clog2(NUM_REGS), register select width (derived, do not override)
- WR_BYPASS, 1, 1 = read ports see the same-cycle write data
- ZERO_REG, 0, 1 = register 0 always reads zero and ignores writes

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_sel1  in  SEL_W  read port 1 register select
- rd_sel2  in  SEL_W  read port 2 register select
- rd_data1  out  LANES×ELEM_W  read port 1 vector
- rd_data2  out  LANES×ELEM_W  read port 2 vector
- wr_en  in  1  write request
- wr_sel  in  SEL_W  destination register
- wr_mask  in  LANES  per-lane write enable; bit k writes lane k
- wr_data  in  LANES×ELEM_W  write vector
- wr_ready  out  1  write port accepts; low while clear engine busy
- clr_req  in  1  start bulk clear (level, sampled in IDLE)
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse after last register cleared

Behaviour:
- Reset (async assert): all registers zero; FSM → IDLE; clear counter 0; clr_busy=0; clr_done=0; wr_ready=1.
- Write acceptance: a write commits at a rising edge iff wr_en & wr_ready & (wr_sel≠0 or ZERO_REG=0).
  - Only lanes with wr_mask[k]=1 update; other lanes hold.
  - wr_mask=0 is a legal no-op.
- Read: combinational, zero latency.
  - If ZERO_REG=1 and sel=0, output all zeros.
  - Else if WR_BYPASS=1, the write commits this cycle, and sel==wr_sel: lane k = wr_mask[k] ? wr_data[k] : stored[k].
  - Otherwise the stored value.
  - Both ports may select the same register.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE: clr_req=1 → CLEAR with cnt=0.
  - CLEAR: each cycle zero all lanes of reg[cnt] and increment cnt. When cnt==NUM_REGS-1, write it, then → DONE.
  - DONE: clr_done=1 for exactly one cycle → IDLE. clr_req still high in DONE does not restart; a restart requires clr_req to be sampled in IDLE.
- Clear timing: takes exactly NUM_REGS cycles in CLEAR.
  - clr_busy=1 in CLEAR and DONE.
  - wr_ready=0 in CLEAR and DONE; external writes are dropped, not queued.
- Reads during clear: return current contents. Already-cleared registers read zero, the rest keep old values. No bypass from clear writes; stored values are used.
- Counter width: SEL_W; no wrap past NUM_REGS-1.
- Reset mid-clear: immediate abort to IDLE; all registers zero anyway; no clr_done pulse.
- Simultaneous clr_req and wr_en in IDLE: the write commits (wr_ready still 1 that cycle) and the FSM enters CLEAR on the same edge. The write is then overwritten when its register is cleared.

Decomposition:
- Package vrf_pkg holds:
  - typedef elem_t (ELEM_W-bit)
  - typedef vec_t (LANES elem_t)
  - enum clr_state_t {IDLE, CLEAR, DONE}
  - default parameter constants
- Sub-module vrf_clear_fsm holds the FSM plus counter. It outputs clr_we, clr_sel, clr_busy, clr_done and wr_ready.
- The top module merges the two write sources and holds the storage array and read muxes.

Test Plan:
- Reset then write reg3 = {0x0004,0x0003,0x0002,0x0001}, mask 4'b1111; next cycle rd_sel1=3 → same vector; rd_sel2=5 → all zero.
- Masked write: reg3 as above, write {0xAAAA×4} with mask 4'b0101 → reg3 reads {0x0004,0xAAAA,0x0002,0xAAAA}.
- Bypass (WR_BYPASS=1): same-cycle wr_sel=2, data 0x1234×4, mask 4'b0011, rd_sel1=2 on old zero contents → rd_data1={0,0,0x1234,0x1234} before the edge. With WR_BYPASS=0 → all zero until the next cycle.
- ZERO_REG=1: write reg0 0xFFFF×4 → rd_sel1=0 reads zero; the same write to reg1 reads 0xFFFF×4.
- Clear: fill all 8 regs nonzero, pulse clr_req → clr_busy high 9 cycles, clr_done one pulse at cycle 9, wr_ready low throughout; a write to reg7 during cycle 2 is dropped; all regs then read zero.
- Async rst asserted mid-clear (cnt=4, off-edge) → immediately clr_busy=0, wr_ready=1, all reads zero, no clr_done.
